// File: rtl/vga_sync_generator.sv
// Free-running VGA raster timing: x/y counters with zero-latency decodes, plus
// hsync/vsync/blank_n delayed PIPE_DELAY clocks to line up with registered pixel data.

module vga_sync_delay #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) pipe <= {DEPTH{RST_VAL}};
        else        pipe <= (pipe << 1) | DEPTH'(d);
    end

    assign q = pipe[DEPTH-1];

endmodule

module vga_sync_generator #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 2      // legal range 1..4
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Delay-chain reset levels, index order {blank_n, vsync, hsync}
    localparam logic [2:0] RST_LVL = {1'b0, ~SYNC_POL, ~SYNC_POL};

    logic       hs_raw;
    logic       vs_raw;
    logic [2:0] raw_lvl;
    logic [2:0] dly_lvl;

    // x/y are the raster counters themselves; both wrap together at frame end
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= 10'd0;
            y <= 10'd0;
        end else if (x == H_LAST) begin
            x <= 10'd0;
            y <= (y == V_LAST) ? 10'd0 : y + 10'd1;
        end else begin
            x <= x + 10'd1;
        end
    end

    always_comb begin
        hs_raw     = (int'(x) >= HS_START) && (int'(x) < HS_END);
        vs_raw     = (int'(y) >= VS_START) && (int'(y) < VS_END);
        video_on   = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
        frame_tick = (x == 10'd0) && (int'(y) == V_ACTIVE);
    end

    assign raw_lvl = {video_on,
                      vs_raw ? SYNC_POL : ~SYNC_POL,
                      hs_raw ? SYNC_POL : ~SYNC_POL};

    for (genvar i = 0; i < 3; i++) begin : g_dly
        vga_sync_delay #(
            .DEPTH   (PIPE_DELAY),
            .RST_VAL (RST_LVL[i])
        ) u_dly (
            .vga_clk (vga_clk),
            .rst_n   (rst_n),
            .d       (raw_lvl[i]),
            .q       (dly_lvl[i])
        );
    end

    assign hsync   = dly_lvl[0];
    assign vsync   = dly_lvl[1];
    assign blank_n = dly_lvl[2];

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: four instances (default timing at PIPE_DELAY 2/1/4,
// plus a tiny active-high raster) compared every cycle against an arithmetic raster model.

module tb_vga_sync_generator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n = 0;            // clocks since reset release
    int   checks = 0;
    int   failures = 0;
    int   last_ft = -1;
    int   hs_low = 0;
    int   vs_high = 0;

    logic [9:0] x  [4];
    logic [9:0] y  [4];
    logic       vo [4];
    logic       hs [4];
    logic       vs [4];
    logic       bl [4];
    logic       ft [4];

    always #5 clk = ~clk;

    vga_sync_generator #(.PIPE_DELAY(2)) u_d2 (
        .vga_clk(clk), .rst_n(rst_n), .x(x[0]), .y(y[0]), .video_on(vo[0]),
        .hsync(hs[0]), .vsync(vs[0]), .blank_n(bl[0]), .frame_tick(ft[0]));
    vga_sync_generator #(.PIPE_DELAY(1)) u_d1 (
        .vga_clk(clk), .rst_n(rst_n), .x(x[1]), .y(y[1]), .video_on(vo[1]),
        .hsync(hs[1]), .vsync(vs[1]), .blank_n(bl[1]), .frame_tick(ft[1]));
    vga_sync_generator #(.PIPE_DELAY(4)) u_d4 (
        .vga_clk(clk), .rst_n(rst_n), .x(x[2]), .y(y[2]), .video_on(vo[2]),
        .hsync(hs[2]), .vsync(vs[2]), .blank_n(bl[2]), .frame_tick(ft[2]));
    vga_sync_generator #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1), .PIPE_DELAY(3)
    ) u_ds (
        .vga_clk(clk), .rst_n(rst_n), .x(x[3]), .y(y[3]), .video_on(vo[3]),
        .hsync(hs[3]), .vsync(vs[3]), .blank_n(bl[3]), .frame_tick(ft[3]));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // Expected {x,y,video_on,frame_tick,hsync,vsync,blank_n} after c clocks of running
    function automatic logic [24:0] model(input int k, input int c);
        int ha, hf, hw, hb, va, vf, vw, vb, pd, ht, vt, p, xx, yy, px, py;
        logic pol, e_vo, e_ft, e_hs, e_vs, e_bl;
        ha = 640; hf = 16; hw = 96; hb = 48;
        va = 480; vf = 10; vw = 2;  vb = 33;
        pol = 1'b0;
        case (k)
            0:       pd = 2;
            1:       pd = 1;
            2:       pd = 4;
            default: begin
                ha = 16; hf = 4; hw = 6; hb = 4;
                va = 12; vf = 2; vw = 2; vb = 3;
                pol = 1'b1; pd = 3;
            end
        endcase
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        p  = c % (ht * vt);
        xx = p % ht;
        yy = p / ht;
        e_vo = (xx < ha) && (yy < va);
        e_ft = (xx == 0) && (yy == va);
        if (c < pd) begin
            e_hs = ~pol; e_vs = ~pol; e_bl = 1'b0;
        end else begin
            p  = (c - pd) % (ht * vt);
            px = p % ht;
            py = p / ht;
            e_hs = (px >= ha + hf && px < ha + hf + hw) ? pol : ~pol;
            e_vs = (py >= va + vf && py < va + vf + vw) ? pol : ~pol;
            e_bl = (px < ha) && (py < va);
        end
        return {10'(xx), 10'(yy), e_vo, e_ft, e_hs, e_vs, e_bl};
    endfunction

    function automatic logic [24:0] actual(input int k);
        return {x[k], y[k], vo[k], ft[k], hs[k], vs[k], bl[k]};
    endfunction

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d actual=%0d expected=%0d", name, n, act, exp);
        end
    endtask

    // Single compare process: fires every cycle and immediately after an async reset
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [24:0] a, e;
            a = actual(k);
            e = model(k, n);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL model_dut%0d n=%0d rst_n=%b actual x/y/vo.ft.hs.vs.bl=%0d/%0d/%b required=%0d/%0d/%b",
                         k, n, rst_n, a[24:15], a[14:5], a[4:0], e[24:15], e[14:5], e[4:0]);
            end
        end

        if (!rst_n) begin
            lit("reset_d2", int'(actual(0)), int'({10'd0, 10'd0, 5'b10110}));
            lit("reset_ds", int'(actual(3)), int'({10'd0, 10'd0, 5'b10000}));
            last_ft = -1; hs_low = 0; vs_high = 0;
        end else begin
            case (n)
                1:   lit("first_edge_x", int'(x[0]), 1);
                641: lit("blank_d2_641", int'(bl[0]), 1);
                642: lit("blank_d2_642", int'(bl[0]), 0);
                656: lit("hsync_d2_656", int'(hs[0]), 1);
                657: lit("hsync_d2_657", int'(hs[0]), 1);
                658: lit("hsync_d2_658", int'(hs[0]), 0);
                657+1-1+0: ;
                default: ;
            endcase
            if (n == 657) lit("hsync_d1_657", int'(hs[1]), 0);
            if (n == 659) lit("hsync_d4_659", int'(hs[2]), 1);
            if (n == 660) lit("hsync_d4_660", int'(hs[2]), 0);
            if (n == 754) lit("hsync_d2_754", int'(hs[0]), 1);
            if (n == 800) lit("wrap_d2_xy", int'({x[0], y[0]}), int'({10'd0, 10'd1}));
            if (n == 360) lit("ft_ds_360", int'(ft[3]), 1);
            if (n == 422) lit("vsync_ds_422", int'(vs[3]), 0);
            if (n == 423) lit("vsync_ds_423", int'(vs[3]), 1);
            if (n == 483) lit("vsync_ds_483", int'(vs[3]), 0);
            if (n == 570) lit("wrap_ds_frame", int'({x[3], y[3]}), 0);

            if (hs[0] == 1'b0) hs_low++;
            else if (hs_low > 0) begin
                lit("hsync_d2_width", hs_low, 96);
                hs_low = 0;
            end
            if (vs[3] == 1'b1) vs_high++;
            else if (vs_high > 0) begin
                lit("vsync_ds_width", vs_high, 60);
                vs_high = 0;
            end
            if (ft[3] == 1'b1) begin
                if (last_ft >= 0) lit("ft_ds_period", n - last_ft, 570);
                last_ft = n;
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(posedge clk);

        for (int it = 0; it < 4; it++) begin
            int hold;
            repeat ($urandom_range(100, 2500)) @(posedge clk);
            #1;
            if (it == 0) begin
                while ((n % 800) != 700) begin
                    @(posedge clk);
                    #1;
                end
            end
            #($urandom_range(1, 2));
            rst_n = 1'b0;
            hold = $urandom_range(1, 4);
            repeat (hold) @(negedge clk);
            rst_n = 1'b1;
        end

        repeat (1500) @(posedge clk);
        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
